fifo_ram_flags: RTL
===================

// Module: fifo_ram_flags
// PURPOSE
//   Parametrised synchronous FIFO that replaces the bare line-buffer FIFO in the Canny pipeline.
//   Tracks occupancy, so full/empty are true flags rather than fixed-depth assumptions.
//   Adds programmable almost-full/almost-empty thresholds, a read-valid strobe, a held read data
//   register and a synchronous reset.
//   Sits between row-scan stages (Gaussian, Sobel, NMS) as a row-delay or elastic buffer.
// PARAMETERS
//   DATA_WIDTH  8    bits per entry
//   DATA_DEPTH  640  entries; any value >= 2, power of 2 not required
//   AF_THRESH   638  wr_almost_full asserts when count >= AF_THRESH (1..DATA_DEPTH)
//   AE_THRESH   2    rd_almost_empty asserts when count <= AE_THRESH (0..DATA_DEPTH-1)
// PORTS
//   clk              in   1                      single clock, all logic on posedge
//   rst              in   1                      synchronous, active-high reset
//   wr_en            in   1                      write request
//   wr_data          in   DATA_WIDTH             write data
//   wr_full          out  1                      count == DATA_DEPTH
//   wr_almost_full   out  1                      count >= AF_THRESH
//   rd_en            in   1                      read request
//   rd_data          out  DATA_WIDTH             registered read data
//   rd_valid         out  1                      rd_data updated this cycle
//   rd_empty         out  1                      count == 0
//   rd_almost_empty  out  1                      count <= AE_THRESH
//   count            out  $clog2(DATA_DEPTH+1)   current occupancy
//   overflow         out  1                      sticky: write attempted while full
//   underflow        out  1                      sticky: read attempted while empty
// BEHAVIOUR
//   - Storage: DATA_DEPTH x DATA_WIDTH array, block-RAM style. wr_ptr and rd_ptr are $clog2(DATA_DEPTH) bits.
//   - Pointer wrap: a pointer at DATA_DEPTH-1 goes to 0 on its next accepted access.
//   - Accept rules, evaluated on registered state:
//       wr_acc = wr_en & ~wr_full
//       rd_acc = rd_en & ~rd_empty
//   - Write when full is dropped, even if rd_en is high the same cycle. Pointers and memory are unchanged.
//   - Read when empty is dropped, even if wr_en is high the same cycle. There is no write-to-read bypass.
//   - wr_acc: mem[wr_ptr] <= wr_data, and wr_ptr advances.
//   - rd_acc: rd_data <= mem[rd_ptr] on the same edge, rd_ptr advances, and rd_valid = 1 for the next cycle.
//     Read latency is exactly 1 clk.
//   - No rd_acc: rd_data holds its previous value (never forced to 0) and rd_valid = 0.
//   - count update: count + wr_acc - rd_acc. A simultaneous accepted read and write leaves count unchanged.
//   - Flags are decoded from registered count only, so they have no combinational path from wr_en/rd_en.
//   - Write and read to the same address cannot occur in one cycle, because full/empty gating prevents it.
//   - rst: wr_ptr = rd_ptr = count = 0; rd_data = 0; rd_valid = 0; rd_empty = 1; wr_full = 0;
//     rd_almost_empty = 1; wr_almost_full = (AF_THRESH == 0 ? 1 : 0), which is 0 for legal values;
//     overflow = underflow = 0.
//   - RAM contents are not cleared. rst has priority over wr_en/rd_en in the same cycle.
//     Reset mid-stream discards all stored data.
// CONFIGURATION
//   FIFO_ERR_FLAGS_EN defined:
//     - overflow sets on wr_en & wr_full; underflow sets on rd_en & rd_empty.
//     - Both stay set until rst.
//   FIFO_ERR_FLAGS_EN undefined:
//     - overflow and underflow are tied to 0; no flag registers are synthesised.
//     - Accept rules are identical in both builds.
// TESTING
//   Use DATA_DEPTH=5, AF_THRESH=4, AE_THRESH=1, DATA_WIDTH=8 unless noted.
//   1. After rst:
//        - write 0x11,0x22,0x33 on consecutive cycles, then read 3
//          -> rd_data 0x11,0x22,0x33 with rd_valid, each 1 clk after its rd_en.
//        - count goes 0..3..0; rd_empty is 1 at the end.
//   2. Fill with 5 writes, then a 6th write of 0xFF
//        -> wr_full = 1, count = 5, the 0xFF is dropped.
//        -> overflow = 1 with macro defined, 0 without.
//        -> draining 5 reads returns the original data.
//   3. Wrap-around: write 7 and read 7, interleaved
//        -> pointers wrap 4 -> 0 and data order is preserved.
//      Also run DATA_DEPTH=640 (non power of 2): 2000 writes and reads, checked against a scoreboard.
//   4. Simultaneous wr_en and rd_en:
//        - at count = 2 -> count stays 2 and data order is kept.
//        - at count = 5 -> read accepted, write dropped, count becomes 4.
//        - at count = 0 -> write accepted, read dropped, count = 1, rd_valid = 0, underflow set if macro defined.
//   5. Thresholds: step count 0..5
//        -> rd_almost_empty = 1 at 0 and 1;
//        -> wr_almost_full = 1 at 4 and 5.
//   6. Assert rst at count = 3 during an active read
//        -> next cycle: count = 0, rd_valid = 0, rd_data = 0, rd_empty = 1.
//        -> a subsequent write/read returns the new data only.

Source files
------------

// File: rtl/fifo_ram_flags_if.sv
// Handshake/status bundle for fifo_ram_flags: write side, read side, occupancy and error flags.
// The master modport drives requests; the slave modport (the FIFO) drives data and status.
interface fifo_ram_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 640
);
    localparam int CW = $clog2(DATA_DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic                  wr_almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_empty;
    logic                  rd_almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, wr_almost_full, rd_data, rd_valid, rd_empty,
               rd_almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, wr_almost_full, rd_data, rd_valid, rd_empty,
               rd_almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram_flags.sv
// Synchronous occupancy-tracking FIFO with almost-full/empty thresholds and a registered read port.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_ram_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 640,
    parameter int AF_THRESH  = 638,
    parameter int AE_THRESH  = 2
) (
    input logic             clk,
    input logic             rst,
    fifo_ram_flags_if.slave fifo
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int CW = $clog2(DATA_DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DATA_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    logic wr_full, rd_empty;
    logic wr_acc, rd_acc;

    // Flags decode from registered occupancy only: no path from wr_en/rd_en.
    assign wr_full  = (count_q == CW'(DATA_DEPTH));
    assign rd_empty = (count_q == '0);

    always_comb begin
        wr_acc = fifo.wr_en & ~wr_full;
        rd_acc = fifo.rd_en & ~rd_empty;

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset so it maps onto block RAM; reset only discards it via the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q] <= fifo.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign fifo.wr_full         = wr_full;
    assign fifo.rd_empty        = rd_empty;
    assign fifo.wr_almost_full  = (count_q >= CW'(AF_THRESH));
    assign fifo.rd_almost_empty = (count_q <= CW'(AE_THRESH));
    assign fifo.count           = count_q;
    assign fifo.rd_data         = rd_data_q;
    assign fifo.rd_valid        = rd_valid_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo.wr_en && wr_full) begin
                overflow_q <= 1'b1;
            end
            if (fifo.rd_en && rd_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`else
    assign fifo.overflow  = 1'b0;
    assign fifo.underflow = 1'b0;
`endif
endmodule
